// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-threshold keypad path.
//   KEY_CLEAR / KEY_ENTER : command key codes from the keypad scanner
//   entry_state_t         : digit-entry FSM states (IDLE / ONE / TWO)
//   MAX_DISTANCE          : largest distance a two-digit entry can produce
package alarm_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam logic [6:0] MAX_DISTANCE = 7'd99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } entry_state_t;

endpackage

// File: rtl/entry_timeout_timer.sv
// Inactivity timer for a partial keypad entry.
//   CLK, RESET : clock (rising edge) and asynchronous active-high reset
//   run        : entry in progress; counter is held at 0 while low
//   restart    : an accepted key this cycle; counter returns to 0
//   expire     : high while running with the counter at TIMEOUT_CYCLES-1
module entry_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TIMER_W        = 26
) (
  input  logic CLK,
  input  logic RESET,
  input  logic run,
  input  logic restart,
  output logic expire
);

  logic [TIMER_W-1:0] count;

  assign expire = run && (count == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (!run || restart || expire) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/digit_entry_accumulator.sv
// Builds a binary alarm-threshold distance (0..99) from decimal keystrokes.
//   CLK, RESET  : clock (rising edge) and asynchronous active-high reset
//   Key_Valid   : one-cycle key strobe; Key_Code valid this cycle
//   Key_Code    : 0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF ignored
//   Value       : last committed distance, binary
//   Value_Valid : one-cycle pulse when Value is updated
//   Entry_BCD   : partial entry, [7:4] tens, [3:0] units, right-justified
//   Digit_Count : digits currently held (0..2)
//   Error       : one-cycle pulse on a rejected key or entry timeout
module digit_entry_accumulator
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TIMER_W        = 26
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       Key_Valid,
  input  logic [3:0] Key_Code,
  output logic [6:0] Value,
  output logic       Value_Valid,
  output logic [7:0] Entry_BCD,
  output logic [1:0] Digit_Count,
  output logic       Error
);

  entry_state_t state, state_n;
  logic [6:0] acc, acc_n;
  logic [7:0] bcd_n;
  logic [6:0] value_n;
  logic       value_valid_n, error_n;

  logic key_digit, key_clear, key_enter;
  logic run, restart, expire;
  logic [6:0] acc_x10;

  assign key_digit = Key_Valid && (Key_Code <= 4'd9);
  assign key_clear = Key_Valid && (Key_Code == KEY_CLEAR);
  assign key_enter = Key_Valid && (Key_Code == KEY_ENTER);

  assign run     = (state != IDLE);
  assign restart = key_digit || key_clear || key_enter;

  // acc <= 9 whenever a second digit arrives, so the 7-bit result never wraps.
  assign acc_x10 = (acc << 3) + (acc << 1);

  entry_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .run    (run),
    .restart(restart),
    .expire (expire)
  );

  always_comb begin
    state_n       = state;
    acc_n         = acc;
    bcd_n         = Entry_BCD;
    value_n       = Value;
    value_valid_n = 1'b0;
    error_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_digit) begin
          state_n = ONE;
          acc_n   = {3'b000, Key_Code};
          bcd_n   = {4'h0, Key_Code};
        end else if (key_enter) begin
          error_n = 1'b1;
        end
      end
      ONE, TWO: begin
        // A key on the expiry cycle takes priority over the timeout.
        if (key_digit) begin
          if (state == ONE) begin
            state_n = TWO;
            acc_n   = acc_x10 + {3'b000, Key_Code};
            bcd_n   = {Entry_BCD[3:0], Key_Code};
          end else begin
            error_n = 1'b1;
          end
        end else if (key_enter) begin
          value_n       = acc;
          value_valid_n = 1'b1;
          state_n       = IDLE;
          acc_n         = '0;
          bcd_n         = '0;
        end else if (key_clear) begin
          state_n = IDLE;
          acc_n   = '0;
          bcd_n   = '0;
        end else if (expire) begin
          state_n = IDLE;
          acc_n   = '0;
          bcd_n   = '0;
          error_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        acc_n   = '0;
        bcd_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      acc         <= '0;
      Entry_BCD   <= '0;
      Value       <= '0;
      Value_Valid <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      Entry_BCD   <= bcd_n;
      Value       <= value_n;
      Value_Valid <= value_valid_n;
      Error       <= error_n;
    end
  end

  always_comb begin
    unique case (state)
      ONE:     Digit_Count = 2'd1;
      TWO:     Digit_Count = 2'd2;
      default: Digit_Count = 2'd0;
    endcase
  end

endmodule
